// File: rtl/apu_pkg.sv
// apu_pkg: shared APU frame-sequencer constants and types.
//   STEPn_NTSC   default APU-cycle counts of each sequence step
//   MODE_*       bit positions inside the $4017 mode field
//   step_t       identifier of the last step reached
package apu_pkg;

    localparam int CNT_W_DEF = 15;

    localparam logic [CNT_W_DEF-1:0] STEP1_NTSC = 15'd3728;
    localparam logic [CNT_W_DEF-1:0] STEP2_NTSC = 15'd7456;
    localparam logic [CNT_W_DEF-1:0] STEP3_NTSC = 15'd11185;
    localparam logic [CNT_W_DEF-1:0] STEP4_NTSC = 15'd14914;
    localparam logic [CNT_W_DEF-1:0] STEP5_NTSC = 15'd18640;

    localparam int MODE_IRQ_INH = 0;
    localparam int MODE_SEQ     = 1;

    typedef enum logic [2:0] {
        STEP_NONE = 3'd0,
        STEP_Q1   = 3'd1,
        STEP_Q2   = 3'd2,
        STEP_Q3   = 3'd3,
        STEP_Q4   = 3'd4,
        STEP_Q5   = 3'd5
    } step_t;

endpackage

// File: rtl/apu_frame_wr_delay.sv
// apu_frame_wr_delay: holds a deferred $4017 write and releases it after WR_DELAY CPU cycles.
//   clk_in, rst_in        clock, synchronous active-high reset (drops any pending write)
//   cpu_cycle_pulse_in    one-clk strobe per CPU cycle; each one counts down the delay
//   mode_wr_in, mode_in   mode-write strobe and value; a new write replaces the pending one
//   apply_out             combinational strobe on the CPU pulse that ends the delay
//   apply_mode_out        mode value to apply
module apu_frame_wr_delay
    import apu_pkg::*;
#(
    parameter int WR_DELAY = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cpu_cycle_pulse_in,
    input  logic       mode_wr_in,
    input  logic [1:0] mode_in,
    output logic       apply_out,
    output logic [1:0] apply_mode_out
);

    logic       pend_valid;
    logic [1:0] pend_mode;
    logic [2:0] pend_dly;
    logic       wr;

    // A write on the same CPU pulse restarts the slot, so it suppresses the apply.
    always_comb begin
        wr             = mode_wr_in & cpu_cycle_pulse_in;
        apply_out      = pend_valid & cpu_cycle_pulse_in & ~wr & (pend_dly == 3'd1);
        apply_mode_out = pend_mode;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_valid <= 1'b0;
            pend_mode  <= 2'b00;
            pend_dly   <= 3'd0;
        end else if (wr) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode_in;
            pend_dly   <= 3'(WR_DELAY);
        end else if (pend_valid && cpu_cycle_pulse_in) begin
            pend_dly   <= pend_dly - 3'd1;
            pend_valid <= (pend_dly != 3'd1);
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: 4/5-step APU frame sequencer with latched frame IRQ and deferred mode writes.
//   clk_in, rst_in         clock, synchronous active-high reset
//   cpu_cycle_pulse_in     one-clk strobe per CPU cycle
//   apu_cycle_pulse_in     one-clk strobe per APU cycle; advances the sequence counter
//   mode_in, mode_wr_in    $4017 value ([0] IRQ inhibit, [1] 5-step) and its write strobe
//   irq_ack_in             $4015 read strobe; clears the IRQ flag
//   e/l/f_pulse_out        registered quarter-frame, half-frame and frame pulses
//   irq_out                latched frame-IRQ flag
//   step_out               last step reached since wrap or apply (0 = none)
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int             CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] STEP1  = CNT_W'(STEP1_NTSC),
    parameter logic [CNT_W-1:0] STEP2  = CNT_W'(STEP2_NTSC),
    parameter logic [CNT_W-1:0] STEP3  = CNT_W'(STEP3_NTSC),
    parameter logic [CNT_W-1:0] STEP4  = CNT_W'(STEP4_NTSC),
    parameter logic [CNT_W-1:0] STEP5  = CNT_W'(STEP5_NTSC),
    parameter int             WR_DELAY = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cpu_cycle_pulse_in,
    input  logic       apu_cycle_pulse_in,
    input  logic [1:0] mode_in,
    input  logic       mode_wr_in,
    input  logic       irq_ack_in,
    output logic       e_pulse_out,
    output logic       l_pulse_out,
    output logic       f_pulse_out,
    output logic       irq_out,
    output logic [2:0] step_out
);

    logic             apply;
    logic [1:0]       apply_mode;
    logic [CNT_W-1:0] cnt;
    logic             seq_mode;
    logic             irq_inhibit;
    logic             irq_flag;
    step_t            step;
    logic             e_r, l_r, f_r;
    logic             inh_wr, tick;
    logic             hit1, hit2, hit3, hit4, hit5, hit_any, irq_set;
    step_t            hit_step;

    apu_frame_wr_delay #(.WR_DELAY(WR_DELAY)) u_wr_delay (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .cpu_cycle_pulse_in (cpu_cycle_pulse_in),
        .mode_wr_in         (mode_wr_in),
        .mode_in            (mode_in),
        .apply_out          (apply),
        .apply_mode_out     (apply_mode)
    );

    // An apply in the same clk as an APU pulse takes precedence, so step matches
    // are only evaluated on pulses without an apply.
    always_comb begin
        inh_wr   = mode_wr_in & cpu_cycle_pulse_in & mode_in[MODE_IRQ_INH];
        tick     = apu_cycle_pulse_in & ~apply;
        hit1     = tick & (cnt == STEP1);
        hit2     = tick & (cnt == STEP2);
        hit3     = tick & (cnt == STEP3);
        hit4     = tick & ~seq_mode & (cnt == STEP4);
        hit5     = tick & seq_mode & (cnt == STEP5);
        hit_any  = hit1 | hit2 | hit3 | hit4 | hit5;
        irq_set  = hit4 & ~irq_inhibit;
        hit_step = hit1 ? STEP_Q1 : hit2 ? STEP_Q2 : hit3 ? STEP_Q3 : hit4 ? STEP_Q4 : STEP_Q5;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt         <= '0;
            seq_mode    <= 1'b0;
            irq_inhibit <= 1'b0;
            irq_flag    <= 1'b0;
            step        <= STEP_NONE;
            e_r         <= 1'b0;
            l_r         <= 1'b0;
            f_r         <= 1'b0;
        end else begin
            e_r <= apply ? apply_mode[MODE_SEQ] : hit_any;
            l_r <= apply ? apply_mode[MODE_SEQ] : (hit2 | hit4 | hit5);
            f_r <= irq_set;
            if (apply) begin
                cnt      <= '0;
                step     <= STEP_NONE;
                seq_mode <= apply_mode[MODE_SEQ];
            end else if (apu_cycle_pulse_in) begin
                cnt <= (hit4 | hit5) ? '0 : cnt + CNT_W'(1);
                if (hit_any) step <= hit_step;
            end
            // apply never coincides with a write, so the two inhibit sources cannot collide.
            irq_inhibit <= inh_wr ? 1'b1 : apply ? apply_mode[MODE_IRQ_INH] : irq_inhibit;
            irq_flag    <= inh_wr ? 1'b0 : irq_set ? 1'b1 : irq_ack_in ? 1'b0 : irq_flag;
        end
    end

    assign e_pulse_out = e_r;
    assign l_pulse_out = l_r;
    assign f_pulse_out = f_r;
    assign irq_out     = irq_flag;
    assign step_out    = step;

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Parametrised successor to the APU frame counter: divides the APU cycle stream into a 4-step or 5-step sequence. It emits envelope (quarter-frame), length/sweep (half-frame) and frame pulses. It adds a latched frame-IRQ flag with acknowledge/inhibit clearing and a programmable CPU-cycle delay between a mode write and its effect. It sits between the CPU register decode ($4017 write, $4015 read) and the pulse, triangle, noise and DMC channel counters.

## Interface
- CNT_W, 15, sequence counter width; every STEPn must fit.
- STEP1, 15'd3728, APU-cycle count of quarter-frame 1.
- STEP2, 15'd7456, count of quarter-frame 2 (also half-frame).
- STEP3, 15'd11185, count of quarter-frame 3.
- STEP4, 15'd14914, 4-step mode final step (quarter+half+frame IRQ, wrap).
- STEP5, 15'd18640, 5-step mode final step (quarter+half, wrap, no IRQ).
- WR_DELAY, 3, CPU-cycle pulses between mode write and application; range 1..7.
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- cpu_cycle_pulse_in  in  1  one-clk strobe per CPU cycle.
- apu_cycle_pulse_in  in  1  one-clk strobe per APU cycle.
- mode_in  in  2  [0] IRQ inhibit, [1] sequence mode (0 = 4-step, 1 = 5-step).
- mode_wr_in  in  1  one-clk mode-write strobe, coincident with cpu_cycle_pulse_in.
- irq_ack_in  in  1  one-clk strobe, status-register read; clears IRQ flag.
- e_pulse_out  out  1  quarter-frame pulse, one clk wide.
- l_pulse_out  out  1  half-frame pulse, one clk wide.
- f_pulse_out  out  1  frame pulse (4-step final step, not inhibited), one clk wide.
- irq_out  out  1  latched frame-IRQ flag, level.
- step_out  out  3  last step reached, 0 = none since wrap/apply, 1..5.

## Operation
- State: cnt[CNT_W-1:0], seq_mode, irq_inhibit, irq_flag, step. Pending-write slot: pend_valid, pend_mode[1:0], pend_dly[2:0].
- On each apu_cycle_pulse_in: compare cnt, then increment.
  - cnt==STEP1 or STEP3 -> e only.
  - cnt==STEP2 -> e+l.
  - 4-step mode, cnt==STEP4 -> e+l, f = ~irq_inhibit, irq_flag set if ~irq_inhibit, cnt <- 0.
  - 5-step mode, cnt==STEP4 -> no event. cnt==STEP5 -> e+l, cnt <- 0.
  - 4-step mode never reaches STEP5. If cnt exceeds the final step (cannot occur after reset), it wraps to 0 at 2^CNT_W.
- step_out updates to 1..5 on each matching event and returns to 0 on apply.
- Mode write (mode_wr_in & cpu_cycle_pulse_in) has two effects:
  - Immediately: if mode_in[0]=1, irq_inhibit <- 1 and irq_flag <- 0 in the same cycle.
  - Deferred: pend_valid <- 1, pend_mode <- mode_in, pend_dly <- WR_DELAY.
- Each cpu_cycle_pulse_in with pend_valid decrements pend_dly. The pulse that brings pend_dly to 0 applies the write: seq_mode/irq_inhibit <- pend_mode, cnt <- 0, step <- 0, pend_valid <- 0. If the new mode is 5-step, e+l pulse on apply.
- irq_ack_in clears irq_flag.

## Timing
- Reset: cnt=0, seq_mode=0, irq_inhibit=0, irq_flag=0, pend_valid=0, step=0. All outputs 0 the cycle after rst_in; rst_in overrides every other input, including a pending write.
- All outputs are registered; pulses appear exactly 1 clk after the qualifying strobe.
- A write applies WR_DELAY CPU pulses after the write strobe; that write strobe is not counted.
- Simultaneous events:
  - Apply and apu pulse in the same clk: apply wins. cnt <- 0; step match pulses are suppressed; only apply-generated e/l appear.
  - New write while pending: replaces pend_mode and restarts pend_dly; only one apply occurs.
  - irq set and irq_ack_in in the same clk: set wins, irq_out=1.
  - irq set and inhibit write in the same clk: inhibit wins, irq_out=0.
- irq_out stays high until ack, inhibit write or reset; it does not self-clear at wrap.

## Structure
- Shared package apu_pkg holds the default STEPn localparams (NTSC) and the mode-bit index constants (MODE_IRQ_INH=0, MODE_SEQ=1).
- Sub-module apu_frame_wr_delay holds the pending slot and delay counter and outputs apply strobe plus applied mode. The sequencer core instantiates it once.

## Test plan
- Reset, 4-step, continuous apu pulses -> e at cnt 3728/7456/11185/14914, l at 7456/14914, f and irq_out=1 at 14914, next e at 3728 after wrap.
- Write mode_in=2'b10 -> after 3 CPU pulses, e+l pulse immediately; then e at 3728/7456/11185/18640, none at 14914, f never, irq_out stays 0.
- irq_out=1, then irq_ack_in -> irq_out=0 next clk. Same test with ack on the 14914 set clk -> irq_out=1.
- irq_out=1, write mode_in=2'b01 -> irq_out=0 next clk, before apply. A later 4-step pass gives f=0, irq_out=0.
- Write 2'b10 then 2'b00 one CPU pulse later -> single apply, 3 CPU pulses after second write, 4-step, no e/l on apply.
- Apply coincident with apu pulse at cnt==STEP2 -> no l from the step, cnt=0; assert rst_in mid-pending -> no apply ever occurs.
